screen_mux_fade: RTL and testbench

Parametrised successor to the game-screen selector. It multiplexes `N_SCREENS` pre-drawn RGB sources onto one VGA stream. Screen changes take effect only at frame boundaries, never mid-frame. Each change is an optional fade-out/fade-in transition driven by a per-frame brightness level. It sits between the screen drawers (start, map, win screens) and the VGA output stage; the top level maps `game_mode` to `sel`.

---
 rtl/game_pkg.sv | 6 +
 rtl/vga_if.sv | 12 +
 rtl/rgb_dim.sv | 15 +
 rtl/screen_mux_fade.sv | 106 ++++++++++
 tb/tb_screen_mux_fade.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared fade FSM states and pixel constants for the screen selector.
package game_pkg;
    typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} fade_state_t;
    localparam logic [3:0] LEVEL_MAX = 4'd15;
    localparam int RGB_W = 12;
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing plus 4:4:4 pixel bundle.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/rgb_dim.sv
// rgb_dim: scales each 4-bit channel of a 4:4:4 pixel by a 4-bit brightness level.
module rgb_dim
    import game_pkg::*;
(
    input  logic [RGB_W-1:0] rgb_i,
    input  logic [3:0]       level_i,
    output logic [RGB_W-1:0] rgb_o
);
    logic [RGB_W-1:0] scaled;
    for (genvar c = 0; c < 3; c++) begin : g_ch
        assign scaled[4*c +: 4] = 4'(({4'd0, rgb_i[4*c +: 4]} * {4'd0, level_i}) >> 4);
    end
    // Full level bypasses the multiply so x*15/16 truncation never dims a steady screen
    assign rgb_o = (level_i == LEVEL_MAX) ? rgb_i : scaled;
endmodule

// File: rtl/screen_mux_fade.sv
// screen_mux_fade: frame-synchronous screen selector with optional fade-out/fade-in.
module screen_mux_fade
    import game_pkg::*;
#(
    parameter int  N_SCREENS    = 4,
    parameter int  STEP_FRAMES  = 2,
    parameter bit  FADE_EN      = 1'b1,
    parameter int  RESET_SCREEN = 0,
    localparam int SEL_W        = $clog2(N_SCREENS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_W-1:0]                sel,
    input  logic [N_SCREENS-1:0][RGB_W-1:0] screen_rgb,
    vga_if.in                               vga_in,
    vga_if.out                              vga_out,
    output logic [SEL_W-1:0]                active_screen,
    output logic                            busy
);
    fade_state_t      state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic             vblnk_q;
    logic             fb;
    logic             pending;
    logic             step_done;
    logic [RGB_W-1:0] dim_rgb;

    assign fb            = vga_in.vblnk & ~vblnk_q;
    assign pending       = target_q != active_q;
    assign step_done     = cnt_q == 8'(STEP_FRAMES - 1);
    assign active_screen = active_q;
    assign busy          = (state_q != STEADY) | pending;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        target_d = (int'(sel) < N_SCREENS) ? sel : target_q;
        if (fb) begin
            case (state_q)
                STEADY: begin
                    if (pending && FADE_EN)
                        state_d = FADE_OUT;
                    else if (pending)
                        active_d = target_q;
                end
                FADE_OUT, FADE_IN: begin
                    cnt_d = step_done ? 8'd0 : cnt_q + 8'd1;
                    if (step_done) begin
                        level_d = (state_q == FADE_OUT) ? level_q - 4'd1 : level_q + 4'd1;
                        // The swap happens at black; whatever target holds now wins
                        if (state_q == FADE_OUT && level_q == 4'd1) begin
                            active_d = target_q;
                            state_d  = FADE_IN;
                        end
                        if (state_q == FADE_IN && level_q == LEVEL_MAX - 4'd1)
                            state_d = STEADY;
                    end
                end
                default: state_d = STEADY;
            endcase
        end
    end

    rgb_dim u_dim (
        .rgb_i   (screen_rgb[active_q]),
        .level_i (level_q),
        .rgb_o   (dim_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= STEADY;
            level_q        <= LEVEL_MAX;
            cnt_q          <= '0;
            active_q       <= SEL_W'(RESET_SCREEN);
            target_q       <= SEL_W'(RESET_SCREEN);
            vblnk_q        <= 1'b0;
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            target_q       <= target_d;
            vblnk_q        <= vga_in.vblnk;
            vga_out.vcount <= vga_in.vcount;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.hcount <= vga_in.hcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.rgb    <= (vga_in.hblnk | vga_in.vblnk) ? '0 : dim_rgb;
        end
    end
endmodule

// File: tb/tb_screen_mux_fade.sv
// tb_screen_mux_fade: randomized check of three screen_mux_fade variants against a frame-level model.
module tb_screen_mux_fade;
    localparam int NS = 5;
    localparam int HT = 16;
    localparam int HV = 10;
    localparam int VT = 8;
    localparam int VV = 5;
    localparam int FR = HT * VT;
    localparam int STEP [3] = '{1, 2, 3};
    localparam bit FADE [3] = '{1'b1, 1'b0, 1'b1};
    localparam int RSCR [3] = '{0, 0, 2};

    logic clk = 1'b0;
    logic rst;
    logic [2:0] sel;
    logic [NS-1:0][11:0] srgb;
    logic [2:0] act [3];
    logic busy [3];
    logic [11:0] o_rgb [3];
    logic [24:0] o_tim [3];

    vga_if vin ();
    vga_if vo0 ();
    vga_if vo1 ();
    vga_if vo2 ();

    screen_mux_fade #(.N_SCREENS(NS), .STEP_FRAMES(1), .FADE_EN(1'b1), .RESET_SCREEN(0)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .screen_rgb(srgb), .vga_in(vin), .vga_out(vo0),
        .active_screen(act[0]), .busy(busy[0]));
    screen_mux_fade #(.N_SCREENS(NS), .STEP_FRAMES(2), .FADE_EN(1'b0), .RESET_SCREEN(0)) dut1 (
        .clk(clk), .rst(rst), .sel(sel), .screen_rgb(srgb), .vga_in(vin), .vga_out(vo1),
        .active_screen(act[1]), .busy(busy[1]));
    screen_mux_fade #(.N_SCREENS(NS), .STEP_FRAMES(3), .FADE_EN(1'b1), .RESET_SCREEN(2)) dut2 (
        .clk(clk), .rst(rst), .sel(sel), .screen_rgb(srgb), .vga_in(vin), .vga_out(vo2),
        .active_screen(act[2]), .busy(busy[2]));

    assign o_rgb[0] = vo0.rgb;
    assign o_rgb[1] = vo1.rgb;
    assign o_rgb[2] = vo2.rgb;
    assign o_tim[0] = {vo0.vcount, vo0.vsync, vo0.vblnk, vo0.hcount, vo0.hsync, vo0.hblnk};
    assign o_tim[1] = {vo1.vcount, vo1.vsync, vo1.vblnk, vo1.hcount, vo1.hsync, vo1.hblnk};
    assign o_tim[2] = {vo2.vcount, vo2.vsync, vo2.vblnk, vo2.hcount, vo2.hsync, vo2.hblnk};

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit armed = 1'b0;
    bit last_vis = 1'b0;
    int hc;
    int vc;
    logic [2:0] sel_nx;
    bit rst_nx;
    bit rnd_rgb;
    logic [11:0] fix_rgb [NS];
    // Model: a fade is a 30-step walk t=0..30 with brightness |15-t|; screen swaps at t=15
    int m_act [3];
    int m_tgt [3];
    int m_t [3];
    int m_sub [3];
    bit m_fad [3];
    bit m_pv;
    logic [11:0] e_rgb [3];
    logic [24:0] e_tim;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dimmed(logic [11:0] c, int lvl);
        logic [11:0] r;
        int ch;
        for (int k = 0; k < 3; k++) begin
            ch = int'(c[4*k +: 4]);
            r[4*k +: 4] = (lvl == 15) ? c[4*k +: 4] : 4'((ch * lvl) / 16);
        end
        return r;
    endfunction

    task automatic tick();
        logic vb, hb, vs, hs;
        int lvl;
        @(negedge clk);
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rgb%0d", i), 32'(o_rgb[i]), 32'(e_rgb[i]));
                chk($sformatf("tim%0d", i), 32'(o_tim[i]), 32'(e_tim));
                chk($sformatf("act%0d", i), 32'(act[i]), 32'(m_act[i]));
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_fad[i] || m_tgt[i] != m_act[i]));
            end
        end
        hc = (hc == HT - 1) ? 0 : hc + 1;
        if (hc == 0) vc = (vc == VT - 1) ? 0 : vc + 1;
        vb = vc >= VV;
        hb = hc >= HV;
        hs = hc == 12 || hc == 13;
        vs = vc == 6;
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hblnk = hb;
        vin.vblnk = vb;
        vin.hsync = hs;
        vin.vsync = vs;
        vin.rgb = 12'($urandom);
        for (int k = 0; k < NS; k++) srgb[k] = rnd_rgb ? 12'($urandom) : fix_rgb[k];
        sel = sel_nx;
        rst = rst_nx;
        last_vis = !(hb || vb);
        if (rst_nx) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] = RSCR[i];
                m_tgt[i] = RSCR[i];
                m_fad[i] = 1'b0;
                m_t[i] = 0;
                m_sub[i] = 0;
                e_rgb[i] = '0;
            end
            m_pv = 1'b0;
            e_tim = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                lvl = !m_fad[i] ? 15 : (m_t[i] < 15 ? 15 - m_t[i] : m_t[i] - 15);
                e_rgb[i] = (hb || vb) ? 12'h000 : dimmed(srgb[m_act[i]], lvl);
                if (vb && !m_pv) begin
                    if (!m_fad[i]) begin
                        if (m_tgt[i] != m_act[i] && FADE[i]) begin
                            m_fad[i] = 1'b1;
                            m_t[i] = 0;
                            m_sub[i] = 0;
                        end else if (m_tgt[i] != m_act[i]) begin
                            m_act[i] = m_tgt[i];
                        end
                    end else begin
                        m_sub[i]++;
                        if (m_sub[i] == STEP[i]) begin
                            m_sub[i] = 0;
                            m_t[i]++;
                            if (m_t[i] == 15) m_act[i] = m_tgt[i];
                            if (m_t[i] == 30) m_fad[i] = 1'b0;
                        end
                    end
                end
                if (int'(sel_nx) < NS) m_tgt[i] = int'(sel_nx);
            end
            m_pv = vb;
            e_tim = {11'(vc), vs, vb, 11'(hc), hs, hb};
        end
        armed = 1'b1;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic next_visible();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!last_vis && k < 4 * FR);
        tick();
        chk("vis_wait", 32'(k < 4 * FR), 32'd1);
    endtask

    task automatic wait_line(int line);
        int k = 0;
        while (!(vc == line && hc == 0) && k < 4 * FR) begin
            tick();
            k++;
        end
        chk("line_wait", 32'(k < 4 * FR), 32'd1);
    endtask

    task automatic wait_step(int t);
        int k = 0;
        while (!(m_fad[0] && m_t[0] == t) && k < 200 * FR) begin
            tick();
            k++;
        end
        chk($sformatf("step%0d_wait", t), 32'(k < 200 * FR), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_fad[0] || m_fad[1] || m_fad[2] || m_tgt[0] != m_act[0] || m_tgt[1] != m_act[1]
                || m_tgt[2] != m_act[2]) && k < 200 * FR) begin
            tick();
            k++;
        end
        chk("idle_wait", 32'(k < 200 * FR), 32'd1);
    endtask

    initial begin
        hc = $urandom_range(HT - 1);
        vc = $urandom_range(VT - 1);
        fix_rgb = '{12'hF84, 12'h0F0, 12'h00F, 12'h123, 12'hABC};
        rnd_rgb = 1'b0;
        sel_nx = 3'd0;
        rst_nx = 1'b1;
        run(3);
        chk("rst_rgb", 32'(o_rgb[0]), 32'h0);
        chk("rst_tim", 32'(o_tim[0]), 32'h0);
        chk("rst_act2", 32'(act[2]), 32'd2);
        chk("rst_busy0", 32'(busy[0]), 32'd0);
        rst_nx = 1'b0;
        run(2 * FR);
        next_visible();
        chk("steady_rgb", 32'(o_rgb[0]), 32'hF84);
        // hard cut on the FADE_EN=0 variant: request mid-frame, swap at next frame boundary
        wait_line(2);
        sel_nx = 3'd2;
        run(2);
        chk("cut_busy", 32'(busy[1]), 32'd1);
        chk("cut_hold", 32'(act[1]), 32'd0);
        wait_line(VV);
        next_visible();
        chk("cut_rgb", 32'(o_rgb[1]), 32'h00F);
        chk("cut_busy_lo", 32'(busy[1]), 32'd0);
        // fade on the STEP_FRAMES=1 variant, retarget at level 8, new request during fade-in
        fix_rgb[0] = 12'hFFF;
        sel_nx = 3'd0;
        wait_idle();
        sel_nx = 3'd1;
        wait_step(1);
        next_visible();
        chk("fade1_rgb", 32'(o_rgb[0]), 32'hDDD);
        wait_step(7);
        sel_nx = 3'd3;
        wait_step(16);
        chk("retarget_act", 32'(act[0]), 32'd3);
        sel_nx = 3'd0;
        wait_step(29);
        run(2 * FR);
        chk("refade_busy", 32'(busy[0]), 32'd1);
        wait_idle();
        sel_nx = 3'(5 + $urandom_range(2));
        run(3 * FR);
        chk("inv_busy0", 32'(busy[0]), 32'd0);
        chk("inv_busy1", 32'(busy[1]), 32'd0);
        chk("inv_act0", 32'(act[0]), 32'd0);
        rnd_rgb = 1'b1;
        repeat (15) begin
            sel_nx = 3'($urandom_range(7));
            run($urandom_range(30, 1500));
        end
        // reset in the middle of a fade-out (level 5)
        sel_nx = 3'd0;
        wait_idle();
        sel_nx = 3'd4;
        wait_step(10);
        rst_nx = 1'b1;
        tick();
        rst_nx = 1'b0;
        sel_nx = 3'd0;
        rnd_rgb = 1'b0;
        tick();
        chk("midrst_rgb", 32'(o_rgb[0]), 32'h0);
        chk("midrst_act", 32'(act[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        wait_line(VV);
        next_visible();
        chk("postrst_full", 32'(o_rgb[0]), 32'hFFF);
        run(2 * FR);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
